// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - shared L1.5 store request type and endianness helpers
//
// Purpose: types and functions shared by the write-through L1.5 store path.
//   - l15_store_req_t : store request as presented to the L1.5 at default widths
//   - swap_bytes      : reverse the byte order of the low nbytes bytes
//   - rev_bits        : reverse the bit order of the low nbits bits
// The helpers operate on a maximum-width container so that they can serve
// any parameterisation; callers cast in and out at their own width.
package wt_cache_pkg;

  localparam int unsigned L15_MAX_DATA_W = 512;
  localparam int unsigned L15_MAX_BE_W   = L15_MAX_DATA_W / 8;

  localparam int unsigned L15_DEF_ADDR_W = 64;
  localparam int unsigned L15_DEF_DATA_W = 64;
  localparam int unsigned L15_DEF_TID_W  = 2;

  typedef struct packed {
    logic [L15_DEF_ADDR_W-1:0]   addr;
    logic [L15_DEF_DATA_W-1:0]   data;
    logic [L15_DEF_DATA_W/8-1:0] be;
    logic [1:0]                  size;
    logic [L15_DEF_TID_W-1:0]    tid;
  } l15_store_req_t;

  // Byte k of the result is byte (nbytes-1-k) of d; bytes above nbytes are 0.
  function automatic logic [L15_MAX_DATA_W-1:0] swap_bytes(
    input logic [L15_MAX_DATA_W-1:0] d,
    input int                        nbytes
  );
    logic [L15_MAX_DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < nbytes; k++) begin
      r[k*8 +: 8] = d[(nbytes-1-k)*8 +: 8];
    end
    return r;
  endfunction

  // Bit k of the result is bit (nbits-1-k) of b; bits above nbits are 0.
  function automatic logic [L15_MAX_BE_W-1:0] rev_bits(
    input logic [L15_MAX_BE_W-1:0] b,
    input int                      nbits
  );
    logic [L15_MAX_BE_W-1:0] r;
    r = '0;
    for (int k = 0; k < nbits; k++) begin
      r[k] = b[nbits-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/wt_l15_tid_alloc.sv
// rtl/wt_l15_tid_alloc.sv - transaction ID pool for the L1.5 store tracker
//
// Purpose: owns the allocated-ID bitmap, picks the lowest free ID, and
// validates returning store-acks.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   alloc_i        : allocate free_tid_o this cycle
//   rtrn_val_i     : store-ack valid
//   rtrn_tid_i     : ID being acked
//   free_tid_o     : lowest-index free ID (from registered bitmap)
//   full_o         : every ID allocated
//   rtrn_hit_o     : ack targets an allocated ID and frees it this cycle
//   err_o          : registered one-cycle pulse for an ack to a free ID
module wt_l15_tid_alloc
  import wt_cache_pkg::*;
#(
  parameter int unsigned TidWidth = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                alloc_i,
  input  logic                rtrn_val_i,
  input  logic [TidWidth-1:0] rtrn_tid_i,
  output logic [TidWidth-1:0] free_tid_o,
  output logic                full_o,
  output logic                rtrn_hit_o,
  output logic                err_o
);

  localparam int unsigned NumTids = 2 ** TidWidth;

  logic [NumTids-1:0] busy_q, busy_d;
  logic               err_q, err_d;
  logic [TidWidth-1:0] free_tid;

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    free_tid = '0;
    for (int i = NumTids - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_tid = TidWidth'(i);
      end
    end
  end

  assign full_o     = &busy_q;
  assign free_tid_o = free_tid;
  assign rtrn_hit_o = rtrn_val_i && busy_q[rtrn_tid_i];

  // The freed ID and the allocated ID can never collide in one cycle: the
  // freed one is busy in busy_q, the allocated one is free in busy_q.
  always_comb begin
    busy_d = busy_q;
    if (rtrn_hit_o) begin
      busy_d[rtrn_tid_i] = 1'b0;
    end
    if (alloc_i) begin
      busy_d[free_tid] = 1'b1;
    end
    err_d = rtrn_val_i && !busy_q[rtrn_tid_i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/wt_l15_store_tracker.sv
// rtl/wt_l15_store_tracker.sv - dcache store to big-endian L1.5 request tracker
//
// Purpose: accepts write-buffer stores, byte-swaps them into L1.5 lane order,
// tags each with a transaction ID, holds it until the L1.5 accepts it, and
// tracks outstanding stores until their acks return.
// Ports:
//   clk_i, rst_ni         : clock, synchronous active-low reset
//   req_*                 : store request in (valid/ready), little-endian lanes
//   l15_val_o / l15_ack_i : request out handshake
//   l15_addr/data/be/size/tid_o : registered big-endian request
//   rtrn_val_i/rtrn_tid_i : store-ack return
//   outstanding_o         : number of IDs allocated
//   idle_o                : nothing allocated and nothing waiting for the L1.5
//   err_o                 : one-cycle pulse on an ack for a free ID
module wt_l15_store_tracker
  import wt_cache_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned BeWidth       = DataWidth / 8,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_data_i,
  input  logic [BeWidth-1:0]   req_be_i,
  input  logic [1:0]           req_size_i,
  output logic                 l15_val_o,
  input  logic                 l15_ack_i,
  output logic [AddrWidth-1:0] l15_addr_o,
  output logic [DataWidth-1:0] l15_data_o,
  output logic [BeWidth-1:0]   l15_be_o,
  output logic [1:0]           l15_size_o,
  output logic [TidWidth-1:0]  l15_tid_o,
  input  logic                 rtrn_val_i,
  input  logic [TidWidth-1:0]  rtrn_tid_i,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 idle_o,
  output logic                 err_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
    logic [BeWidth-1:0]   be;
    logic [1:0]           size;
    logic [TidWidth-1:0]  tid;
  } req_t;

  req_t                req_q, req_d;
  logic                val_q, val_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic                accept;
  logic [TidWidth-1:0] free_tid;
  logic                pool_full;
  logic                rtrn_hit;

  wt_l15_tid_alloc #(
    .TidWidth (TidWidth)
  ) i_tid_alloc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .alloc_i    (accept),
    .rtrn_val_i (rtrn_val_i),
    .rtrn_tid_i (rtrn_tid_i),
    .free_tid_o (free_tid),
    .full_o     (pool_full),
    .rtrn_hit_o (rtrn_hit),
    .err_o      (err_o)
  );

  // Ready depends only on registered state plus l15_ack_i, so an ID freed by
  // a return this cycle does not open the gate until next cycle.
  assign req_ready_o = (!val_q || l15_ack_i) && !pool_full
                       && (cnt_q < CntWidth'(MaxOutstanding));
  assign accept      = req_valid_i && req_ready_o;

  // The output register reloads on accept even while the current request is
  // being acked, giving back-to-back issue.
  always_comb begin
    val_d = val_q;
    req_d = req_q;
    if (accept) begin
      val_d      = 1'b1;
      req_d.addr = req_addr_i;
      req_d.data = DataWidth'(swap_bytes(L15_MAX_DATA_W'(req_data_i), int'(BeWidth)));
      req_d.be   = BeWidth'(rev_bits(L15_MAX_BE_W'(req_be_i), int'(BeWidth)));
      req_d.size = req_size_i;
      req_d.tid  = free_tid;
    end else if (l15_ack_i) begin
      val_d = 1'b0;
    end
  end

  // The ready gating bounds the increment and the hit check bounds the
  // decrement, so the counter needs no saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rtrn_hit) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && rtrn_hit) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      val_q <= 1'b0;
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end

  assign l15_val_o     = val_q;
  assign l15_addr_o    = req_q.addr;
  assign l15_data_o    = req_q.data;
  assign l15_be_o      = req_q.be;
  assign l15_size_o    = req_q.size;
  assign l15_tid_o     = req_q.tid;
  assign outstanding_o = cnt_q;
  assign idle_o        = (cnt_q == '0) && !val_q;

endmodule
